// File: rtl/csma_tx_scheduler.sv
// csma_tx_scheduler: CSMA/CD transmit sequencing with carrier defer, collision jam and truncated binary exponential backoff.
// Optional macro CSMA_TX_RANDOM_EN: draw the backoff slot count from the LFSR; when undefined the full window (2^k-1 slots) is used.
module csma_tx_scheduler #(
    parameter int         FRAME_LEN    = 4,
    parameter int         JAM_LEN      = 2,
    parameter int         SLOT         = 4,
    parameter int         MAX_EXP      = 3,
    parameter int         MAX_ATTEMPTS = 4,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       finished_bt,
    input  logic       CS,
    input  logic       CD,
    output logic [1:0] ack,
    output logic [1:0] send_bt,
    output logic [3:0] attempts,
    output logic       busy
);
    localparam logic [1:0] ACK_FAIL = 2'd0, ACK_SUCCESS = 2'd1, ACK_NA = 2'd2;
    localparam logic [1:0] SEND_JAM = 2'd0, SEND_F = 2'd1, SEND_ND = 2'd2;
    localparam int BW = $clog2(((1 << MAX_EXP) - 1) * SLOT + 1);
    localparam int CW = $clog2((FRAME_LEN > JAM_LEN ? FRAME_LEN : JAM_LEN) + 1);

    typedef enum logic [2:0] {IDLE, DEFER, XMIT, WAITFIN, JAM, BACKOFF, DONE, COOL} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [BW-1:0] r_bo;
    logic [7:0]    r_lfsr;
    logic [1:0]    r_ack;
    logic [1:0]    r_send;
    logic [3:0]    r_attempts;
    logic          r_busy;
    logic [3:0]    w_att_nx;
    logic [3:0]    w_k;
    logic [7:0]    w_mask;
    logic [7:0]    w_r;
    logic [BW-1:0] w_delay;

    assign ack      = r_ack;
    assign send_bt  = r_send;
    assign attempts = r_attempts;
    assign busy     = r_busy;

    // Backoff delay for the collision being closed: the exponent uses the post-increment attempt count
    always_comb begin
        w_att_nx = r_attempts + 4'd1;
        w_k      = (w_att_nx > 4'(MAX_EXP)) ? 4'(MAX_EXP) : w_att_nx;
        w_mask   = (8'd1 << w_k) - 8'd1;
`ifdef CSMA_TX_RANDOM_EN
        w_r      = r_lfsr & w_mask;
`else
        w_r      = w_mask;
`endif
        w_delay  = BW'(32'(w_r) * SLOT);
    end

    // Free-running x^8+x^6+x^5+x^4+1 Fibonacci LFSR, advancing in every state
    always_ff @(posedge clk) begin
        if (reset)
            r_lfsr <= LFSR_SEED;
        else
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end

    // Scheduler FSM; ack/send default to idle values so pulses last exactly one cycle, busy tracks next state != IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bo       <= '0;
            r_ack      <= ACK_NA;
            r_send     <= SEND_ND;
            r_attempts <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_ack  <= ACK_NA;
            r_send <= SEND_ND;
            r_busy <= 1'b1;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!req) begin
                        r_busy <= 1'b0;
                    end else if (CS) begin
                        r_state <= DEFER;
                    end else begin
                        r_state <= XMIT;
                        r_send  <= SEND_F;
                    end
                end
                DEFER: begin
                    r_cnt <= '0;
                    if (!req) begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_attempts <= '0;
                    end else if (!CS) begin
                        r_state <= XMIT;
                        r_send  <= SEND_F;
                    end
                end
                XMIT: begin
                    if (CD) begin
                        r_state <= JAM;
                        r_cnt   <= '0;
                        r_send  <= SEND_JAM;
                    end else if (r_cnt == CW'(FRAME_LEN - 1)) begin
                        r_state <= WAITFIN;
                    end else begin
                        r_cnt  <= r_cnt + CW'(1);
                        r_send <= SEND_F;
                    end
                end
                WAITFIN: begin
                    if (finished_bt) begin
                        r_state <= DONE;
                        r_ack   <= ACK_SUCCESS;
                    end
                end
                JAM: begin
                    if (r_cnt == CW'(JAM_LEN - 1)) begin
                        r_attempts <= w_att_nx;
                        if (w_att_nx == 4'(MAX_ATTEMPTS)) begin
                            r_state <= DONE;
                            r_ack   <= ACK_FAIL;
                        end else begin
                            r_bo    <= w_delay;
                            r_state <= (w_delay == '0) ? DEFER : BACKOFF;
                        end
                    end else begin
                        r_cnt  <= r_cnt + CW'(1);
                        r_send <= SEND_JAM;
                    end
                end
                BACKOFF: begin
                    r_bo <= r_bo - BW'(1);
                    if (!req) begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_attempts <= '0;
                    end else if (r_bo == BW'(1)) begin
                        r_state <= DEFER;
                    end
                end
                DONE: begin
                    r_state    <= COOL;
                    r_attempts <= '0;
                end
                COOL: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_csma_tx_scheduler.sv
// tb_csma_tx_scheduler: directed and randomized checks of csma_tx_scheduler against a sequential behavioural model.
module tb_csma_tx_scheduler;
    localparam logic [1:0] A_FAIL = 2'd0, A_SUCC = 2'd1, A_NA = 2'd2;
    localparam logic [1:0] S_JAM = 2'd0, S_F = 2'd1, S_ND = 2'd2;
    localparam int FRAME_LEN = 4, JAM_LEN = 2, SLOT = 4, MAX_EXP = 3, MAX_ATTEMPTS = 4;
    localparam logic [7:0] SEED = 8'hA5;

    logic clk = 1'b0, reset = 1'b1, req = 1'b0, finished_bt = 1'b0, CS = 1'b0, CD = 1'b0;
    logic [1:0] ack, send_bt;
    logic [3:0] attempts;
    logic       busy;

    int n_chk = 0, n_fail = 0;
    logic [1:0] e_ack = A_NA, e_send = S_ND;
    logic [3:0] e_att = 4'd0;
    logic       e_busy = 1'b0;
    logic [7:0] m_lfsr = SEED, m_lf = SEED;
    bit         m_rst, armed = 1'b0, done;
    int         bo_log[$];
    int         gaps[$];
    int         attv[$];
    int         exp_gap[3] = '{5, 13, 29};
    int         exp_att[5] = '{1, 2, 3, 4, 0};
    int         n, d1, gap, nfail;
    logic [3:0] last_att;

    csma_tx_scheduler #(
        .FRAME_LEN(FRAME_LEN), .JAM_LEN(JAM_LEN), .SLOT(SLOT),
        .MAX_EXP(MAX_EXP), .MAX_ATTEMPTS(MAX_ATTEMPTS), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .finished_bt(finished_bt), .CS(CS), .CD(CD),
        .ack(ack), .send_bt(send_bt), .attempts(attempts), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    task automatic set_exp(input logic [1:0] a, input logic [1:0] s, input int at, input logic b);
        e_ack  = a;
        e_send = s;
        e_att  = at[3:0];
        e_busy = b;
    endtask

    // One clock edge of the model: remember the LFSR value seen by this edge, then sample reset
    task automatic tick();
        m_lf = m_lfsr;
        @(posedge clk);
        m_rst  = reset;
        m_lfsr = reset ? SEED : lfsr_next(m_lfsr);
    endtask

    task automatic finish(input logic [1:0] a, input int att);
        set_exp(a, S_ND, att, 1'b1);
        tick();
        if (m_rst) return;
        set_exp(A_NA, S_ND, 0, 1'b1);
        tick();
    endtask

    // A whole request lifetime written as a sequential story; every return leaves the station idle
    task automatic run_station();
        int  att, k, r, d;
        bit  defer, coll;
        att = 0;
        do tick(); while (m_rst || !req);
        defer = CS;
        forever begin
            while (defer) begin
                set_exp(A_NA, S_ND, att, 1'b1);
                tick();
                if (m_rst || !req) return;
                defer = CS;
            end
            coll = 1'b0;
            for (int i = 0; i < FRAME_LEN && !coll; i++) begin
                set_exp(A_NA, S_F, att, 1'b1);
                tick();
                if (m_rst) return;
                coll = CD;
            end
            if (!coll) begin
                do begin
                    set_exp(A_NA, S_ND, att, 1'b1);
                    tick();
                    if (m_rst) return;
                end while (!finished_bt);
                finish(A_SUCC, att);
                return;
            end
            for (int j = 0; j < JAM_LEN; j++) begin
                set_exp(A_NA, S_JAM, att, 1'b1);
                tick();
                if (m_rst) return;
            end
            att++;
            if (att == MAX_ATTEMPTS) begin
                finish(A_FAIL, att);
                return;
            end
            k = att < MAX_EXP ? att : MAX_EXP;
`ifdef CSMA_TX_RANDOM_EN
            r = int'(m_lf) % (1 << k);
`else
            r = (1 << k) - 1;
`endif
            d = r * SLOT;
            bo_log.push_back(d);
            for (int b = 0; b < d; b++) begin
                set_exp(A_NA, S_ND, att, 1'b1);
                tick();
                if (m_rst || !req) return;
            end
            defer = 1'b1;
        end
    endtask

    initial forever begin
        run_station();
        set_exp(A_NA, S_ND, 0, 1'b0);
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("ack", ack, e_ack);
            chk("send_bt", send_bt, e_send);
            chk("attempts", attempts, e_att);
            chk("busy", busy, e_busy);
        end
    end

    // Let a collision-free frame finish: pulse finished_bt once the F symbols end, then expect Success
    task automatic complete(input string tag);
        int w;
        w = 0;
        while (!(send_bt == S_ND && busy) && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_waitfin"}, w < 40, 1);
        finished_bt = 1'b1;
        @(negedge clk);
        finished_bt = 1'b0;
        chk({tag, "_ack"}, ack, A_SUCC);
        req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        armed = 1'b1;
        reset = 1'b0;
        chk("model_lfsr0", m_lfsr, 8'hA5);
        @(negedge clk);
        chk("model_lfsr1", m_lfsr, 8'h4A);
        @(negedge clk);
        chk("model_lfsr2", m_lfsr, 8'h95);
        @(negedge clk);
        chk("model_lfsr3", m_lfsr, 8'h2A);

        // clean send
        req = 1'b1;
        CS  = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c <= 4) chk("clean_F", send_bt, S_F);
            else if (c <= 6) chk("clean_ND", send_bt, S_ND);
            if (c == 7) chk("clean_succ", ack, A_SUCC);
            if (c == 8) chk("clean_na", ack, A_NA);
            if (c == 9) chk("clean_idle", busy, 0);
            chk("clean_att", attempts, 0);
            if (c == 6) finished_bt = 1'b1;
            if (c == 7) begin
                finished_bt = 1'b0;
                req = 1'b0;
            end
        end

        // defer while carrier sensed
        repeat (2) @(negedge clk);
        req = 1'b1;
        CS  = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("defer_ND", send_bt, S_ND);
            chk("defer_busy", busy, 1);
        end
        CS = 1'b0;
        @(negedge clk);
        chk("defer_F", send_bt, S_F);
        complete("defer");

        // single collision on the second F edge
        bo_log.delete();
        d1  = 4;
        req = 1'b1;
        for (int c = 1; c <= 6 + d1; c++) begin
            @(negedge clk);
`ifdef CSMA_TX_RANDOM_EN
            if (c == 5) d1 = (bo_log.size() > 0) ? bo_log[0] : 0;
`endif
            if (c <= 2) chk("col_F", send_bt, S_F);
            else if (c <= 4) chk("col_jam", send_bt, S_JAM);
            else if (c <= 5 + d1) chk("col_ND", send_bt, S_ND);
            else chk("col_F_again", send_bt, S_F);
            chk("col_att", attempts, c <= 4 ? 0 : 1);
            if (c == 2) CD = 1'b1;
            if (c == 3) CD = 1'b0;
        end
        complete("col");

        // collide on every attempt until Fail
        bo_log.delete();
        gaps.delete();
        attv.delete();
        req = 1'b1;
        CD  = 1'b1;
        gap = -1;
        nfail = 0;
        done = 1'b0;
        last_att = 4'd0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (attempts != last_att) begin
                attv.push_back(int'(attempts));
                last_att = attempts;
            end
            if (send_bt == S_JAM) gap = 0;
            else if (send_bt == S_ND && gap >= 0 && ack == A_NA) gap++;
            else if (send_bt == S_F && gap >= 0) begin
                gaps.push_back(gap);
                gap = -1;
            end
            if (ack == A_FAIL) begin
                nfail++;
                gap = -1;
                req = 1'b0;
                CD  = 1'b0;
            end
            if (nfail > 0 && !busy) done = 1'b1;
        end
        chk("xs_done", done, 1);
        chk("xs_fail_cycles", nfail, 1);
        chk("xs_natt", attv.size(), 5);
        for (int i = 0; i < 5 && i < attv.size(); i++) chk("xs_att_step", attv[i], exp_att[i]);
        chk("xs_ngaps", gaps.size(), 3);
        chk("xs_nbo", bo_log.size(), 3);
        for (int i = 0; i < 3 && i < gaps.size() && i < bo_log.size(); i++) begin
`ifdef CSMA_TX_RANDOM_EN
            chk("xs_gap", gaps[i], bo_log[i] + 1);
            chk("xs_mult4", bo_log[i] % 4, 0);
            chk("xs_window", bo_log[i] <= 4 * ((2 << i) - 1), 1);
`else
            chk("xs_gap", gaps[i], exp_gap[i]);
            chk("xs_model_bo", bo_log[i], exp_gap[i] - 1);
`endif
        end
        repeat (2) @(negedge clk);

        // abort during backoff
        req = 1'b1;
        CS  = 1'b0;
        CD  = 1'b1;
        n = 0;
        while (send_bt != S_JAM && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ab_jam_seen", send_bt, S_JAM);
        CD = 1'b0;
        CS = 1'b1;
        n = 0;
        while (attempts != 4'd1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ab_att1", attempts, 1);
        chk("ab_busy", busy, 1);
        req = 1'b0;
        @(negedge clk);
        chk("ab_idle", busy, 0);
        chk("ab_ack", ack, A_NA);
        chk("ab_att0", attempts, 0);
        @(negedge clk);
        chk("ab_ack2", ack, A_NA);
        CS = 1'b0;

        // reset during the second jam
        req = 1'b1;
        CD  = 1'b1;
        n = 0;
        while (!(attempts == 4'd1 && send_bt == S_JAM) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("rs_jam2_seen", attempts == 4'd1 && send_bt == S_JAM, 1);
        reset = 1'b1;
        CD    = 1'b0;
        req   = 1'b0;
        @(negedge clk);
        chk("rs_send", send_bt, S_ND);
        chk("rs_att", attempts, 0);
        chk("rs_busy", busy, 0);
        chk("rs_ack", ack, A_NA);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (ack != A_NA || $urandom_range(0, 99) < 3) req = 1'b0;
            else if ($urandom_range(0, 99) < 25) req = 1'b1;
            CS          = $urandom_range(0, 99) < 35;
            CD          = $urandom_range(0, 99) < 25;
            finished_bt = $urandom_range(0, 99) < 30;
            reset       = $urandom_range(0, 999) < 4;
        end
        reset = 1'b0;
        req = 1'b0;
        CS = 1'b0;
        CD = 1'b0;
        finished_bt = 1'b0;
        repeat (60) @(negedge clk);
        chk("final_idle", busy, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
